// File: rtl/ap_dc_cmd_issuer.sv
// ap_dc_cmd_issuer: issues data-cache commands from decoded AP instructions, tracking the
// mapped DDR region and its dirty state. Optional watchdog enabled by macro DC_TIMEOUT_EN.
module ap_dc_cmd_issuer #(
    parameter int unsigned DATA_CACHE_DEPTH = 16,
    parameter int unsigned DDR_ADDR_WIDTH   = 28,
    parameter int unsigned TIMEOUT_CYCLES   = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    input  logic [2:0]                instr_op,
    input  logic [DDR_ADDR_WIDTH-1:0] instr_addr,
    output logic                      instr_ready,
    input  logic                      flush_req,
    output logic [2:0]                data_cmd,
    output logic                      store_ddr_en,
    input  logic [3:0]                dc_state,
    output logic [DDR_ADDR_WIDTH-1:0] dc_base_addr,
    output logic                      dirty,
    output logic                      cmd_done,
    output logic                      cmd_err,
    output logic                      dc_timeout
);
    localparam int unsigned IDX_W = $clog2(DATA_CACHE_DEPTH);
    localparam int unsigned TAG_W = DDR_ADDR_WIDTH - IDX_W;

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_ISSUE, S_WAIT_DONE, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic [TAG_W-1:0] r_new_tag, w_new_tag_nxt;
    logic [TAG_W-1:0] r_cur_tag, w_cur_tag_nxt;
    logic             r_tag_valid, w_tag_valid_nxt;
    logic             r_pending, w_pending_nxt;
    logic             r_err, w_err_nxt;
    logic             r_instr_ready, w_instr_ready_nxt;
    logic [2:0]       r_data_cmd, w_data_cmd_nxt;
    logic             r_store_ddr_en, w_store_ddr_en_nxt;
    logic             r_dirty, w_dirty_nxt;
    logic             r_cmd_done, w_cmd_done_nxt;
    logic             r_cmd_err, w_cmd_err_nxt;

    logic [TAG_W-1:0] w_addr_tag;
    logic             w_op_legal;
    logic             w_need_wb;
    logic             w_is_store;
    logic             w_to_hit;
    logic             w_unused_addr;

    assign w_addr_tag    = instr_addr[DDR_ADDR_WIDTH-1:IDX_W];
    assign w_unused_addr = ^instr_addr[IDX_W-1:0];
    assign w_op_legal    = (instr_op >= 3'd1) && (instr_op <= 3'd5);
    assign w_need_wb     = r_dirty && r_tag_valid && (w_addr_tag != r_cur_tag);
    assign w_is_store    = (r_op == 3'd2) || (r_op == 3'd4);

    // Cache state in which each op is known to be executing.
    function automatic logic [3:0] exec_state(input logic [2:0] op);
        case (op)
            3'd1:    exec_state = 4'd4;
            3'd2:    exec_state = 4'd6;
            3'd3:    exec_state = 4'd5;
            3'd4:    exec_state = 4'd7;
            3'd5:    exec_state = 4'd8;
            default: exec_state = 4'd0;
        endcase
    endfunction

    always_comb begin
        w_state_nxt        = r_state;
        w_op_nxt           = r_op;
        w_new_tag_nxt      = r_new_tag;
        w_cur_tag_nxt      = r_cur_tag;
        w_tag_valid_nxt    = r_tag_valid;
        w_pending_nxt      = r_pending;
        w_err_nxt          = r_err;
        w_instr_ready_nxt  = r_instr_ready;
        w_data_cmd_nxt     = r_data_cmd;
        w_store_ddr_en_nxt = r_store_ddr_en;
        w_dirty_nxt        = r_dirty;
        w_cmd_done_nxt     = 1'b0;
        w_cmd_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_instr_ready && instr_valid) begin
                    w_instr_ready_nxt = 1'b0;
                    w_op_nxt          = instr_op;
                    w_new_tag_nxt     = w_addr_tag;
                    w_err_nxt         = 1'b0;
                    if (!w_op_legal) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_need_wb) begin
                        w_pending_nxt      = 1'b1;
                        w_store_ddr_en_nxt = 1'b1;
                        w_state_nxt        = S_FLUSH;
                    end else begin
                        w_cur_tag_nxt   = w_addr_tag;
                        w_tag_valid_nxt = 1'b1;
                        w_data_cmd_nxt  = instr_op;
                        w_state_nxt     = S_ISSUE;
                    end
                end else if (r_instr_ready && flush_req) begin
                    w_instr_ready_nxt = 1'b0;
                    w_pending_nxt     = 1'b0;
                    w_err_nxt         = 1'b0;
                    if (r_dirty) begin
                        w_store_ddr_en_nxt = 1'b1;
                        w_state_nxt        = S_FLUSH;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else if (!r_instr_ready) begin
                    // Re-arm one cycle after the cmd_done pulse.
                    w_instr_ready_nxt = 1'b1;
                end
            end
            S_FLUSH: begin
                if (dc_state == 4'd10) begin
                    w_store_ddr_en_nxt = 1'b0;
                    w_dirty_nxt        = 1'b0;
                    if (r_pending) begin
                        w_cur_tag_nxt   = r_new_tag;
                        w_tag_valid_nxt = 1'b1;
                        w_data_cmd_nxt  = r_op;
                        w_state_nxt     = S_ISSUE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (dc_state == exec_state(r_op)) begin
                    w_data_cmd_nxt = 3'd0;
                    w_state_nxt    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (dc_state == 4'd0) begin
                    if (w_is_store) begin
                        w_dirty_nxt = 1'b1;
                    end
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_cmd_done_nxt = 1'b1;
                w_cmd_err_nxt  = r_err;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Watchdog abort: drop both cache requests, keep region bookkeeping intact.
        if (w_to_hit) begin
            w_data_cmd_nxt     = 3'd0;
            w_store_ddr_en_nxt = 1'b0;
            w_dirty_nxt        = r_dirty;
            w_cur_tag_nxt      = r_cur_tag;
            w_tag_valid_nxt    = r_tag_valid;
            w_err_nxt          = 1'b1;
            w_state_nxt        = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_op           <= '0;
            r_new_tag      <= '0;
            r_cur_tag      <= '0;
            r_tag_valid    <= 1'b0;
            r_pending      <= 1'b0;
            r_err          <= 1'b0;
            r_instr_ready  <= 1'b1;
            r_data_cmd     <= '0;
            r_store_ddr_en <= 1'b0;
            r_dirty        <= 1'b0;
            r_cmd_done     <= 1'b0;
            r_cmd_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_op           <= w_op_nxt;
            r_new_tag      <= w_new_tag_nxt;
            r_cur_tag      <= w_cur_tag_nxt;
            r_tag_valid    <= w_tag_valid_nxt;
            r_pending      <= w_pending_nxt;
            r_err          <= w_err_nxt;
            r_instr_ready  <= w_instr_ready_nxt;
            r_data_cmd     <= w_data_cmd_nxt;
            r_store_ddr_en <= w_store_ddr_en_nxt;
            r_dirty        <= w_dirty_nxt;
            r_cmd_done     <= w_cmd_done_nxt;
            r_cmd_err      <= w_cmd_err_nxt;
        end
    end

`ifdef DC_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 12) ? $clog2(TIMEOUT_CYCLES) : 12;

    logic [CNT_W-1:0] r_cnt;
    logic             r_dc_timeout;
    logic             w_cnt_active;

    assign w_cnt_active = (r_state == S_FLUSH) || (r_state == S_ISSUE) || (r_state == S_WAIT_DONE);
    assign w_to_hit     = w_cnt_active && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign dc_timeout   = r_dc_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_dc_timeout <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_active) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_to_hit) begin
                r_dc_timeout <= 1'b1;
            end
        end
    end
`else
    logic w_unused_param;
    assign w_unused_param = ^TIMEOUT_CYCLES;
    assign w_to_hit       = 1'b0;
    assign dc_timeout     = 1'b0;
`endif

    assign instr_ready  = r_instr_ready;
    assign data_cmd     = r_data_cmd;
    assign store_ddr_en = r_store_ddr_en;
    assign dc_base_addr = {r_cur_tag, {IDX_W{1'b0}}};
    assign dirty        = r_dirty;
    assign cmd_done     = r_cmd_done;
    assign cmd_err      = r_cmd_err;

endmodule

// File: tb/tb_ap_dc_cmd_issuer.sv
// Directed bench for ap_dc_cmd_issuer: per-cycle vector table plus hand-written
// sequences for flush, instruction/flush race, reset mid-flush and (with DC_TIMEOUT_EN) watchdog.
module tb_ap_dc_cmd_issuer;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [2:0]  instr_op;
    logic [27:0] instr_addr;
    logic        instr_ready;
    logic        flush_req;
    logic [2:0]  data_cmd;
    logic        store_ddr_en;
    logic [3:0]  dc_state;
    logic [27:0] dc_base_addr;
    logic        dirty;
    logic        cmd_done;
    logic        cmd_err;
    logic        dc_timeout;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    ap_dc_cmd_issuer #(
        .DATA_CACHE_DEPTH(16),
        .DDR_ADDR_WIDTH  (28),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_op    (instr_op),
        .instr_addr  (instr_addr),
        .instr_ready (instr_ready),
        .flush_req   (flush_req),
        .data_cmd    (data_cmd),
        .store_ddr_en(store_ddr_en),
        .dc_state    (dc_state),
        .dc_base_addr(dc_base_addr),
        .dirty       (dirty),
        .cmd_done    (cmd_done),
        .cmd_err     (cmd_err),
        .dc_timeout  (dc_timeout)
    );

    typedef struct packed {
        logic        v;
        logic [2:0]  op;
        logic [27:0] addr;
        logic        fl;
        logic [3:0]  ds;
        logic        rdy;
        logic [2:0]  cmd;
        logic        st;
        logic [27:0] base;
        logic        d;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl [30];

    function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [27:0] addr,
                                input logic [3:0] ds, input logic rdy, input logic [2:0] cmd,
                                input logic st, input logic [27:0] base, input logic d,
                                input logic done, input logic err);
        vec_t r;
        r.v = v; r.op = op; r.addr = addr; r.fl = 1'b0; r.ds = ds;
        r.rdy = rdy; r.cmd = cmd; r.st = st; r.base = base; r.d = d; r.done = done; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [27:0] addr,
                         input logic fl, input logic [3:0] ds);
        instr_valid = v;
        instr_op    = op;
        instr_addr  = addr;
        flush_req   = fl;
        dc_state    = ds;
    endtask

    initial begin
        //             v  op  addr    ds  | rdy cmd st base    d  done err
        tbl[0]  = mk(1, 1, 28'h40, 0,   1, 0, 0, 28'h0,  0, 0, 0);
        tbl[1]  = mk(0, 0, 28'h0,  1,   0, 1, 0, 28'h40, 0, 0, 0);
        tbl[2]  = mk(0, 0, 28'h0,  4,   0, 1, 0, 28'h40, 0, 0, 0);
        tbl[3]  = mk(0, 0, 28'h0,  4,   0, 0, 0, 28'h40, 0, 0, 0);
        tbl[4]  = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h40, 0, 0, 0);
        tbl[5]  = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h40, 0, 0, 0);
        tbl[6]  = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h40, 0, 1, 0);
        tbl[7]  = mk(1, 2, 28'h40, 0,   1, 0, 0, 28'h40, 0, 0, 0);
        tbl[8]  = mk(0, 0, 28'h0,  1,   0, 2, 0, 28'h40, 0, 0, 0);
        tbl[9]  = mk(0, 0, 28'h0,  6,   0, 2, 0, 28'h40, 0, 0, 0);
        tbl[10] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h40, 0, 0, 0);
        tbl[11] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h40, 1, 0, 0);
        tbl[12] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h40, 1, 1, 0);
        tbl[13] = mk(1, 1, 28'h80, 0,   1, 0, 0, 28'h40, 1, 0, 0);
        tbl[14] = mk(0, 0, 28'h0,  3,   0, 0, 1, 28'h40, 1, 0, 0);
        tbl[15] = mk(0, 0, 28'h0,  10,  0, 0, 1, 28'h40, 1, 0, 0);
        tbl[16] = mk(0, 0, 28'h0,  4,   0, 1, 0, 28'h80, 0, 0, 0);
        tbl[17] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h80, 0, 0, 0);
        tbl[18] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h80, 0, 0, 0);
        tbl[19] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h80, 0, 1, 0);
        tbl[20] = mk(1, 6, 28'h0,  0,   1, 0, 0, 28'h80, 0, 0, 0);
        tbl[21] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h80, 0, 0, 0);
        tbl[22] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h80, 0, 1, 1);
        tbl[23] = mk(1, 4, 28'h85, 0,   1, 0, 0, 28'h80, 0, 0, 0);
        tbl[24] = mk(0, 0, 28'h0,  7,   0, 4, 0, 28'h80, 0, 0, 0);
        tbl[25] = mk(0, 0, 28'h0,  7,   0, 0, 0, 28'h80, 0, 0, 0);
        tbl[26] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h80, 0, 0, 0);
        tbl[27] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h80, 1, 0, 0);
        tbl[28] = mk(0, 0, 28'h0,  0,   0, 0, 0, 28'h80, 1, 1, 0);
        tbl[29] = mk(0, 0, 28'h0,  0,   1, 0, 0, 28'h80, 1, 0, 0);

        rst = 1'b1;
        drive(0, 0, 28'h0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst.ready", {31'd0, instr_ready}, 32'd1);
        chk("rst.outs", {21'd0, data_cmd, store_ddr_en, dirty, cmd_done, cmd_err, dc_timeout}, 32'd0);
        chk("rst.base", {4'd0, dc_base_addr}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d.ready", i), {31'd0, instr_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("v%0d.cmd", i), {29'd0, data_cmd}, {29'd0, tbl[i].cmd});
            chk($sformatf("v%0d.store", i), {31'd0, store_ddr_en}, {31'd0, tbl[i].st});
            chk($sformatf("v%0d.base", i), {4'd0, dc_base_addr}, {4'd0, tbl[i].base});
            chk($sformatf("v%0d.dirty", i), {31'd0, dirty}, {31'd0, tbl[i].d});
            chk($sformatf("v%0d.done", i), {31'd0, cmd_done}, {31'd0, tbl[i].done});
            chk($sformatf("v%0d.err", i), {31'd0, cmd_err}, {31'd0, tbl[i].err});
            chk($sformatf("v%0d.tmo", i), {31'd0, dc_timeout}, 32'd0);
            chk($sformatf("v%0d.excl", i), {31'd0, store_ddr_en && (data_cmd != 3'd0)}, 32'd0);
            drive(tbl[i].v, tbl[i].op, tbl[i].addr, tbl[i].fl, tbl[i].ds);
        end

        // Instruction and flush raised together: op3 on the (dirty) current region first.
        drive(1, 3, 28'h80, 1, 0);
        @(negedge clk); chk("race.cmd", {29'd0, data_cmd}, 32'd3);
        chk("race.store", {31'd0, store_ddr_en}, 32'd0);
        drive(0, 0, 28'h0, 1, 5);
        @(negedge clk); chk("race.cmd0", {29'd0, data_cmd}, 32'd0);
        drive(0, 0, 28'h0, 1, 0);
        @(negedge clk); chk("race.nodone", {31'd0, cmd_done}, 32'd0);
        @(negedge clk); chk("race.done", {31'd0, cmd_done}, 32'd1);
        chk("race.dirty", {31'd0, dirty}, 32'd1);
        @(negedge clk); chk("race.ready", {31'd0, instr_ready}, 32'd1);
        @(negedge clk); chk("fl.store", {31'd0, store_ddr_en}, 32'd1);
        chk("fl.cmd", {29'd0, data_cmd}, 32'd0);
        chk("fl.base", {4'd0, dc_base_addr}, 32'h80);
        drive(0, 0, 28'h0, 1, 3);
        @(negedge clk); chk("fl.store2", {31'd0, store_ddr_en}, 32'd1);
        chk("fl.cmd2", {29'd0, data_cmd}, 32'd0);
        drive(0, 0, 28'h0, 1, 10);
        @(negedge clk); chk("fl.store0", {31'd0, store_ddr_en}, 32'd0);
        chk("fl.dirty0", {31'd0, dirty}, 32'd0);
        chk("fl.cmd3", {29'd0, data_cmd}, 32'd0);
        drive(0, 0, 28'h0, 0, 0);
        @(negedge clk); chk("fl.done", {31'd0, cmd_done}, 32'd1);
        chk("fl.err", {31'd0, cmd_err}, 32'd0);
        @(negedge clk); chk("fl.ready", {31'd0, instr_ready}, 32'd1);

        // Flush on a clean region: completes without any write-back.
        drive(0, 0, 28'h0, 1, 0);
        @(negedge clk); chk("cfl.store", {31'd0, store_ddr_en}, 32'd0);
        drive(0, 0, 28'h0, 0, 0);
        @(negedge clk); chk("cfl.done", {31'd0, cmd_done}, 32'd1);
        chk("cfl.store2", {31'd0, store_ddr_en}, 32'd0);
        @(negedge clk); chk("cfl.ready", {31'd0, instr_ready}, 32'd1);

        // Dirty region 0x100, then a miss to 0x200 and reset during its write-back.
        drive(1, 2, 28'h100, 0, 0);
        @(negedge clk); chk("rf.cmd", {29'd0, data_cmd}, 32'd2);
        drive(0, 0, 28'h0, 0, 6);
        @(negedge clk); drive(0, 0, 28'h0, 0, 0);
        @(negedge clk);
        @(negedge clk); chk("rf.dirty", {31'd0, dirty}, 32'd1);
        @(negedge clk); drive(1, 1, 28'h200, 0, 0);
        @(negedge clk); chk("rf.store", {31'd0, store_ddr_en}, 32'd1);
        chk("rf.base", {4'd0, dc_base_addr}, 32'h100);
        drive(0, 0, 28'h0, 0, 3);
        #2 rst = 1'b1;
        #1;
        chk("rf.store0", {31'd0, store_ddr_en}, 32'd0);
        chk("rf.dirty0", {31'd0, dirty}, 32'd0);
        chk("rf.base0", {4'd0, dc_base_addr}, 32'd0);
        chk("rf.ready", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 28'h0, 0, 0);

`ifdef DC_TIMEOUT_EN
        // Cache stuck in START: watchdog aborts after 16 cycles in ISSUE.
        @(negedge clk); drive(1, 1, 28'h0, 0, 1);
        @(negedge clk); drive(0, 0, 28'h0, 0, 1);
        repeat (15) @(negedge clk);
        chk("to.cmd", {29'd0, data_cmd}, 32'd1);
        chk("to.flag0", {31'd0, dc_timeout}, 32'd0);
        @(negedge clk); chk("to.cmd0", {29'd0, data_cmd}, 32'd0);
        chk("to.flag", {31'd0, dc_timeout}, 32'd1);
        @(negedge clk); chk("to.done", {31'd0, cmd_done}, 32'd1);
        chk("to.err", {31'd0, cmd_err}, 32'd1);
        @(negedge clk); chk("to.sticky", {31'd0, dc_timeout}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
